// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: buffers (PC, instr) pairs in order,
// back-pressures fetch when full, and drops everything on a redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [XLEN-1:0]            enq_pc,
    input  logic [XLEN-1:0]            enq_instr,
    output logic                       stall_fetch,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_instr,
    output logic                       deq_misaligned,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [DEPTH-1:0] mis_mem;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          enq_fire;
    logic          deq_fire;
    logic          empty;

    assign empty       = (cnt == '0);
    assign stall_fetch = (cnt == CW'(DEPTH));
    assign deq_valid   = !empty && !flush;
    assign enq_fire    = enq_valid && !stall_fetch && !flush;
    assign deq_fire    = deq_valid && deq_ready;
    assign count       = cnt;

    // Stale storage is masked whenever the queue is empty.
    assign deq_pc         = empty ? '0 : pc_mem[rd_ptr];
    assign deq_instr      = empty ? '0 : instr_mem[rd_ptr];
    assign deq_misaligned = empty ? 1'b0 : mis_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            if (enq_fire && !deq_fire)      cnt <= cnt + 1'b1;
            else if (!enq_fire && deq_fire) cnt <= cnt - 1'b1;
        end
    end

    // Contents are never cleared; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (enq_fire && !reset) begin
            pc_mem[wr_ptr]    <= enq_pc;
            instr_mem[wr_ptr] <= enq_instr;
            mis_mem[wr_ptr]   <= (enq_pc[1:0] != 2'b00);
        end
    end
endmodule
